prbs16_checker: RTL
===================

PRBS16_CHECKER -- requirements
Module: prbs16_checker

Interface
REQ-001 Parameter LOCK_CNT, default 32: consecutive correct predictions in VERIFY needed to declare lock.
REQ-002 Parameter WINDOW, default 256: length of the error-observation window while locked, in valid bits.
REQ-003 Parameter ERR_THRESH, default 8: errors within one window that force loss of lock.
REQ-004 Parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-005 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 clear_i  input  1  synchronous clear of err_cnt_o and bit_cnt_o.
REQ-008 valid_i  input  1  bit_i carries a received sequence bit this cycle.
REQ-009 bit_i  input  1  received PRBS bit.
REQ-010 locked_o  output  1  checker is synchronised to the sequence.
REQ-011 err_o  output  1  one-cycle pulse: the previous valid bit mismatched while locked.
REQ-012 err_cnt_o  output  CNT_WIDTH  saturating count of mismatches while locked.
REQ-013 bit_cnt_o  output  CNT_WIDTH  saturating count of valid bits checked while locked.

Function
REQ-014 The checker SHALL implement the sequence s' = {s[14:0], p}, with predicted bit p = ~(s[15]^s[12]^s[5]^s[1]) over the 16-bit checker register s.
REQ-015 Cycles with valid_i=0 SHALL leave all state, counters and s unchanged and SHALL hold err_o=0.
REQ-016 States: FILL, VERIFY, LOCKED; reset state FILL.
REQ-017 FILL: each valid bit SHALL shift into s (s <= {s[14:0], bit_i}) and increment a 4-bit fill count; on the 16th bit the FSM SHALL go to VERIFY.
REQ-018 VERIFY: each valid bit SHALL shift bit_i into s; bit_i==p increments good count, mismatch clears it; the FSM stays in VERIFY.
REQ-019 VERIFY: if the updated s equals 16'hFFFF (XNOR lock-up pattern), good count SHALL be cleared regardless of match.
REQ-020 VERIFY: when good count reaches LOCK_CNT, the FSM SHALL go to LOCKED; locked_o SHALL be 1 in the cycle after that bit.
REQ-021 LOCKED: s SHALL shift in p (not bit_i), so single received errors do not propagate.
REQ-022 LOCKED: each valid bit increments bit_cnt_o and a window counter; a mismatch SHALL pulse err_o the next cycle, increment err_cnt_o and increment the window error count.
REQ-023 err_cnt_o and bit_cnt_o SHALL saturate at all-ones, with no wrap.
REQ-024 LOCKED: if window errors including the current bit reach ERR_THRESH, the FSM SHALL go to FILL (fill count 0, good count 0), and locked_o SHALL be 0 the next cycle; this takes priority over window wrap.
REQ-025 When the window counter completes WINDOW bits without loss of lock, it and the window error count SHALL both clear to 0.
REQ-026 clear_i SHALL zero err_cnt_o and bit_cnt_o, taking priority over a simultaneous increment (result 0); err_o still pulses, and FSM and s are unaffected.
REQ-027 Entering FILL from LOCKED SHALL retain s contents but overwrite them through 16 fresh received bits before VERIFY.
REQ-028 All outputs SHALL be registered; locked_o and err_o have one-cycle latency from the deciding valid bit.

Reset
REQ-029 rst_ni=0 SHALL asynchronously force state FILL, s=16'h0000, all internal counters 0, locked_o=0, err_o=0, err_cnt_o=0, bit_cnt_o=0.
REQ-030 Reset asserted mid-operation, including while LOCKED, SHALL discard all progress; after release, synchronisation restarts from FILL.

Verification
REQ-031 Reset with valid_i toggling -> all outputs 0, with no lock while rst_ni=0.
REQ-032 Continuous clean stream from generator seeded 16'h0000 -> locked_o=1 in the cycle after the 48th valid bit; err_cnt_o=0; bit_cnt_o=N after N further bits.
REQ-033 Locked, single bit inverted -> exactly one err_o pulse, err_cnt_o=1, locked_o stays 1, and no further errors.
REQ-034 Locked, 8 inversions within 256 bits -> locked_o=0 after the 8th; with clean bits, relock after 48 more valid bits; err_cnt_o=8 is retained.
REQ-035 Locked, 7 errors per 256-bit window for 4 windows -> lock held, err_cnt_o=28.
REQ-036 Constant bit_i=1 for 1000 bits -> locked_o never asserts; then a clean stream with 1-of-3 valid_i gaps -> lock after 48 valid bits, and clear_i coincident with an error -> err_cnt_o=0.

Source files
------------

// File: rtl/prbs16_checker.sv
// PRBS16 (XNOR, taps 16/13/6/2) receive checker with fill/verify/lock acquisition,
// windowed loss-of-lock detection and saturating error/bit statistics.
module prbs16_checker #(
    parameter int LOCK_CNT   = 32,
    parameter int WINDOW     = 256,
    parameter int ERR_THRESH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic                 bit_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    output logic [CNT_WIDTH-1:0] bit_cnt_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);

    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW);
    localparam logic [EW-1:0] ERR_LIM   = EW'(ERR_THRESH);

    typedef enum logic [1:0] {
        FILL,
        VERIFY,
        LOCKED
    } state_t;

    state_t        state;
    logic [15:0]   s;
    logic [3:0]    fill_cnt;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;

    logic          pred;
    logic          mismatch;
    logic [15:0]   s_rx;
    logic [GW-1:0] good_inc;
    logic [WW-1:0] win_inc;
    logic [EW-1:0] win_err_inc;

    assign pred        = ~(s[15] ^ s[12] ^ s[5] ^ s[1]);
    assign mismatch    = bit_i ^ pred;
    assign s_rx        = {s[14:0], bit_i};
    assign good_inc    = good_cnt + 1'b1;
    assign win_inc     = win_cnt + 1'b1;
    assign win_err_inc = win_err + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= FILL;
            s         <= 16'h0000;
            fill_cnt  <= 4'd0;
            good_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
            bit_cnt_o <= '0;
        end else begin
            err_o <= 1'b0;
            if (valid_i) begin
                case (state)
                    FILL: begin
                        s <= s_rx;
                        if (fill_cnt == 4'd15) begin
                            fill_cnt <= 4'd0;
                            state    <= VERIFY;
                        end else begin
                            fill_cnt <= fill_cnt + 4'd1;
                        end
                    end
                    VERIFY: begin
                        s <= s_rx;
                        // All-ones is the XNOR lock-up state: it predicts itself forever.
                        if (s_rx == 16'hFFFF || mismatch) begin
                            good_cnt <= '0;
                        end else if (good_inc == LOCK_LAST) begin
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                            locked_o <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            good_cnt <= good_inc;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so a received error is not fed back.
                        s <= {s[14:0], pred};
                        if (bit_cnt_o != '1) bit_cnt_o <= bit_cnt_o + 1'b1;
                        if (mismatch) begin
                            err_o <= 1'b1;
                            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                        end
                        if (mismatch && win_err_inc >= ERR_LIM) begin
                            state    <= FILL;
                            locked_o <= 1'b0;
                            fill_cnt <= 4'd0;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (win_inc == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_inc;
                            if (mismatch) win_err <= win_err_inc;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
            if (clear_i) begin
                err_cnt_o <= '0;
                bit_cnt_o <= '0;
            end
        end
    end

endmodule
